sum_fifo: RTL and testbench

SUM_FIFO -- requirements
Module: sum_fifo

---
 rtl/sum_fifo.sv | 97 +++++++++
 tb/tb_sum_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_fifo.sv
// sum_fifo: FIFO that stores the (optionally saturated) sum of two unsigned
// operands together with its carry bit. One-cycle registered read latency,
// sticky overflow/underflow error flags.
module sum_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in0,
    input  logic [N-1:0]           in1,
    input  logic                   in_en,
    input  logic                   out_en,
    input  logic                   clr_err,
    output logic [N-1:0]           out,
    output logic                   out_carry,
    output logic                   out_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf_err,
    output logic                   udf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [N:0]    sum;
    logic [N-1:0]  word;
    logic [N:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [CW-1:0] cnt_nxt;

    assign sum    = {1'b0, in0} + {1'b0, in1};
    assign wr_acc = in_en & ~full;
    assign rd_acc = out_en & ~empty;

    // Stored word: low N bits of the sum, or all-ones on carry in saturate mode
    always_comb begin
        word = sum[N-1:0];
        if (SAT && sum[N])
            word = '1;
    end

    // Next occupancy; simultaneous accepted read and write cancel out
    always_comb begin
        cnt_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = count + CW'(1);
            2'b01:   cnt_nxt = count - CW'(1);
            default: cnt_nxt = count;
        endcase
    end

    // Storage array without reset so it maps onto inferred RAM
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= {sum[N], word};
    end

    // Pointers, occupancy flags, read data register and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            out       <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out       <= mem[rd_ptr][N-1:0];
                out_carry <= mem[rd_ptr][N];
            end
            out_valid <= rd_acc;
            count     <= cnt_nxt;
            full      <= (cnt_nxt == DEPTH_C);
            empty     <= (cnt_nxt == '0);
            // A new error in the clearing cycle wins over clr_err
            ovf_err   <= (in_en & full)   | (ovf_err & ~clr_err);
            udf_err   <= (out_en & empty) | (udf_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sum_fifo.sv
// tb_sum_fifo: directed tests for sum_fifo. Two instances share stimulus:
// u_wrap (SAT=0) and u_sat (SAT=1), both N=8, DEPTH=4.
module tb_sum_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in0, in1;
    logic       in_en, out_en, clr_err;

    logic [7:0] w_out, s_out;
    logic       w_carry, s_carry, w_valid, s_valid;
    logic       w_full, s_full, w_empty, s_empty;
    logic [2:0] w_count, s_count;
    logic       w_ovf, s_ovf, w_udf, s_udf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sum_fifo #(.N(8), .DEPTH(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in_en(in_en),
        .out_en(out_en), .clr_err(clr_err), .out(w_out), .out_carry(w_carry),
        .out_valid(w_valid), .full(w_full), .empty(w_empty), .count(w_count),
        .ovf_err(w_ovf), .udf_err(w_udf)
    );

    sum_fifo #(.N(8), .DEPTH(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in_en(in_en),
        .out_en(out_en), .clr_err(clr_err), .out(s_out), .out_carry(s_carry),
        .out_valid(s_valid), .full(s_full), .empty(s_empty), .count(s_count),
        .ovf_err(s_ovf), .udf_err(s_udf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] b,
                         input logic re, input logic ce);
        in_en   = we;
        in0     = a;
        in1     = b;
        out_en  = re;
        clr_err = ce;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        #3;
        total++;
        if ({w_count, w_full, w_empty, w_out, w_carry, w_valid, w_ovf, w_udf} !==
            {3'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_wrap: got cnt=%0d f=%b e=%b out=%0d c=%b v=%b o=%b u=%b, need 0 0 1 0 0 0 0 0",
                     w_count, w_full, w_empty, w_out, w_carry, w_valid, w_ovf, w_udf);
        end
        total++;
        if ({s_count, s_full, s_empty, s_out, s_carry, s_valid, s_ovf, s_udf} !==
            {3'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_sat: got cnt=%0d f=%b e=%b out=%0d c=%b v=%b o=%b u=%b, need 0 0 1 0 0 0 0 0",
                     s_count, s_full, s_empty, s_out, s_carry, s_valid, s_ovf, s_udf);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap_sum;
        drive(1'b1, 8'd200, 8'd100, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_count, w_empty, w_valid} !== {3'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL wrap_push: got cnt=%0d e=%b v=%b, need 1 0 0", w_count, w_empty, w_valid);
        end
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_out, w_carry, w_valid, w_count} !== {8'd44, 1'b1, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL wrap_read: got out=%0d c=%b v=%b cnt=%0d, need 44 1 1 0",
                     w_out, w_carry, w_valid, w_count);
        end
        total++;
        if ({s_out, s_carry, s_valid} !== {8'd255, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sat_read1: got out=%0d c=%b v=%b, need 255 1 1", s_out, s_carry, s_valid);
        end
        tick();
        total++;
        if ({w_out, w_carry, w_valid} !== {8'd44, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wrap_hold: got out=%0d c=%b v=%b, need 44 1 0", w_out, w_carry, w_valid);
        end
    endtask

    task automatic test_sat_sum;
        drive(1'b1, 8'd200, 8'd100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        tick();
        total++;
        if ({s_out, s_carry, s_valid} !== {8'd255, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sat_first: got out=%0d c=%b v=%b, need 255 1 1", s_out, s_carry, s_valid);
        end
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({s_out, s_carry, s_valid, s_empty} !== {8'd7, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sat_second: got out=%0d c=%b v=%b e=%b, need 7 0 1 1",
                     s_out, s_carry, s_valid, s_empty);
        end
        total++;
        if ({w_out, w_carry} !== {8'd7, 1'b0}) begin
            bad++;
            $display("FAIL wrap_second: got out=%0d c=%b, need 7 0", w_out, w_carry);
        end
    endtask

    task automatic test_full;
        logic [7:0] exp_q [4];
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(10 + i), 8'(i), 1'b0, 1'b0);
            exp_q[i] = 8'(10 + 2 * i);
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_count, w_full, w_empty, w_ovf} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL full_flags: got cnt=%0d f=%b e=%b o=%b, need 4 1 0 0",
                     w_count, w_full, w_empty, w_ovf);
        end
        drive(1'b1, 8'd99, 8'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_count, w_full, w_ovf, s_ovf} !== {3'd4, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL overflow: got cnt=%0d f=%b o=%b so=%b, need 4 1 1 1",
                     w_count, w_full, w_ovf, s_ovf);
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
        total++;
        if (w_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %b, need 0", w_ovf);
        end
        // full with both requests: only the read is accepted
        drive(1'b1, 8'd99, 8'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_count, w_full, w_ovf, w_out, w_valid} !== {3'd3, 1'b0, 1'b1, exp_q[0], 1'b1}) begin
            bad++;
            $display("FAIL full_both: got cnt=%0d f=%b o=%b out=%0d v=%b, need 3 0 1 %0d 1",
                     w_count, w_full, w_ovf, w_out, w_valid, exp_q[0]);
        end
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            tick();
            total++;
            if ({w_out, w_valid} !== {exp_q[i], 1'b1}) begin
                bad++;
                $display("FAIL full_order%0d: got out=%0d v=%b, need %0d 1", i, w_out, w_valid, exp_q[i]);
            end
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_count, w_empty, w_ovf} !== {3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL full_drain: got cnt=%0d e=%b o=%b, need 0 1 0", w_count, w_empty, w_ovf);
        end
    endtask

    task automatic test_underflow;
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        tick();
        total++;
        if ({w_udf, w_valid, w_count} !== {1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL underflow: got u=%b v=%b cnt=%0d, need 1 0 0", w_udf, w_valid, w_count);
        end
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        tick();
        total++;
        if (w_udf !== 1'b1) begin
            bad++;
            $display("FAIL udf_priority: got %b, need 1", w_udf);
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
        total++;
        if (w_udf !== 1'b0) begin
            bad++;
            $display("FAIL udf_clear: got %b, need 0", w_udf);
        end
        // empty with both requests: write accepted, no fall-through read
        drive(1'b1, 8'd5, 8'd6, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        total++;
        if ({w_count, w_empty, w_udf, w_valid} !== {3'd1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL empty_both: got cnt=%0d e=%b u=%b v=%b, need 1 0 1 0",
                     w_count, w_empty, w_udf, w_valid);
        end
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        total++;
        if ({w_out, w_valid, w_count} !== {8'd11, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL empty_both_read: got out=%0d v=%b cnt=%0d, need 11 1 0", w_out, w_valid, w_count);
        end
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_ptr_wrap;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 8'(7 * k), 8'(k), 1'b0, 1'b0);
            tick();
            drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            total++;
            if (w_count !== 3'd1) begin
                bad++;
                $display("FAIL wrap_cnt%0d: got %0d, need 1", k, w_count);
            end
            tick();
            drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            total++;
            if ({w_out, w_valid, w_count} !== {8'(8 * k), 1'b1, 3'd0}) begin
                bad++;
                $display("FAIL wrap_data%0d: got out=%0d v=%b cnt=%0d, need %0d 1 0",
                         k, w_out, w_valid, w_count, 8 * k);
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'd0, 8'd1, 1'b1, 1'b0);
        total++;
        if ({w_count, w_out} !== {3'd3, 8'd80}) begin
            bad++;
            $display("FAIL pre_reset: got cnt=%0d out=%0d, need 3 80", w_count, w_out);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({w_count, w_full, w_empty, w_out, w_carry, w_valid, w_ovf, w_udf} !==
            {3'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got cnt=%0d f=%b e=%b out=%0d c=%b v=%b o=%b u=%b, need 0 0 1 0 0 0 0 0",
                     w_count, w_full, w_empty, w_out, w_carry, w_valid, w_ovf, w_udf);
        end
        // write requested in the cycle reset releases is taken at the next edge
        drive(1'b1, 8'd50, 8'd27, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        total++;
        if ({w_count, w_empty} !== {3'd1, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_push: got cnt=%0d e=%b, need 1 0", w_count, w_empty);
        end
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        total++;
        if ({w_out, w_carry, w_valid, w_count} !== {8'd77, 1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL post_reset_read: got out=%0d c=%b v=%b cnt=%0d, need 77 0 1 0",
                     w_out, w_carry, w_valid, w_count);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_sum();
        test_sat_sum();
        test_full();
        test_underflow();
        test_ptr_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
